// File: rtl/npu_arc_halt_seq.sv
// ARC core halt/run sequencer: walks the command mask one core at a time,
// drives the per-core halt request and waits for a synchronized acknowledge.
module npu_arc_halt_seq #(
  parameter int N_CORES = 18,
  parameter int TMO_CYC = 1023
) (
  input  logic               clk,
  input  logic               rst_a,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_halt,
  input  logic [N_CORES-1:0] cmd_mask,
  input  logic [N_CORES-1:0] halt_ack,
  input  logic [N_CORES-1:0] run_ack,
  output logic [N_CORES-1:0] halt_req_a,
  output logic [N_CORES-1:0] halted,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [N_CORES-1:0] err_mask
);

  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [N_CORES-1:0] halt_m;
  logic [N_CORES-1:0] halt_s;
  logic [N_CORES-1:0] run_m;
  logic [N_CORES-1:0] run_s;
  logic [N_CORES-1:0] rem;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      lsb;
  logic [15:0]        cnt;
  logic               op;
  logic               accept;
  logic               hit;
  logic               tmo;

  // acks come from other clock domains
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      halt_m <= '0;
      halt_s <= '0;
      run_m  <= '0;
      run_s  <= '0;
    end else begin
      halt_m <= halt_ack;
      halt_s <= halt_m;
      run_m  <= run_ack;
      run_s  <= run_m;
    end
  end

  always_comb begin
    lsb = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (rem[i]) lsb = IW'(i);
    end
  end

  assign accept = cmd_valid & cmd_ready;
  assign hit    = op ? halt_s[idx] : run_s[idx];
  assign tmo    = (cnt == 16'(TMO_CYC));

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    state_nxt = (rem == '0) ? DONE : WAIT;
      WAIT:    if (hit || tmo) state_nxt = SCAN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE) & ~rst_a;
    busy      = (state != IDLE);
    done      = (state == DONE);
    err       = (state == DONE) & (|err_mask);
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      op         <= 1'b0;
      rem        <= '0;
      idx        <= '0;
      cnt        <= '0;
      halt_req_a <= '0;
      halted     <= '0;
      err_mask   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op       <= cmd_halt;
            rem      <= cmd_mask & (cmd_halt ? ~halted : halted);
            err_mask <= '0;
          end
        end
        SCAN: begin
          if (rem != '0) begin
            idx             <= lsb;
            halt_req_a[lsb] <= op;
            cnt             <= '0;
          end
        end
        WAIT: begin
          // success wins over a same-cycle timeout
          if (hit) begin
            halted[idx] <= op;
            rem[idx]    <= 1'b0;
          end else if (tmo) begin
            err_mask[idx] <= 1'b1;
            rem[idx]      <= 1'b0;
            if (op) halt_req_a[idx] <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_arc_halt_seq.sv
// Randomized scoreboard bench for npu_arc_halt_seq with a simple
// per-core acknowledge responder and a command-level reference model.
module tb_npu_arc_halt_seq;

  localparam int N   = 18;
  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst_a = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_halt = 1'b0;
  logic [N-1:0] cmd_mask = '0;
  logic [N-1:0] halt_ack = '0;
  logic [N-1:0] run_ack = '0;
  logic [N-1:0] halt_req_a;
  logic [N-1:0] halted;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] err_mask;

  npu_arc_halt_seq #(.N_CORES(N), .TMO_CYC(TMO)) dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_halt  (cmd_halt),
    .cmd_mask  (cmd_mask),
    .halt_ack  (halt_ack),
    .run_ack   (run_ack),
    .halt_req_a(halt_req_a),
    .halted    (halted),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_mask  (err_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] halted;
    logic [N-1:0] req;
    logic [N-1:0] errm;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   req_q[$];

  int tests = 0;
  int fails = 0;
  int n_issued = 0;
  int n_done = 0;

  logic [N-1:0] m_halted = '0;
  logic [N-1:0] m_req = '0;
  logic [N-1:0] alive = '1;
  int           dly = 4;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // responder: ack follows the request after dly negedges if the core is alive
  initial begin
    logic [N-1:0] hist [0:4];
    for (int i = 0; i < 5; i++) hist[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = halt_req_a;
      halt_ack = alive & hist[dly];
      run_ack  = alive & ~hist[dly];
    end
  end

  // command-level model: ascending walk, alive cores succeed, dead ones time out
  task automatic model_cmd(input logic op, input logic [N-1:0] mask);
    logic [N-1:0] tgt;
    logic [N-1:0] errm;
    exp_t e;
    tgt  = mask & (op ? ~m_halted : m_halted);
    errm = '0;
    for (int i = 0; i < N; i++) begin
      if (tgt[i]) begin
        if (m_req[i] != op) req_q.push_back(i);
        m_req[i] = op;
        if (alive[i]) begin
          m_halted[i] = op;
        end else begin
          errm[i] = 1'b1;
          if (op) begin
            req_q.push_back(i);
            m_req[i] = 1'b0;
          end
        end
      end
    end
    e.halted = m_halted;
    e.req    = m_req;
    e.errm   = errm;
    e.err    = |errm;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic issue(input logic op, input logic [N-1:0] mask);
    wait_ready();
    model_cmd(op, mask);
    n_issued++;
    cmd_valid = 1'b1;
    cmd_halt  = op;
    cmd_mask  = mask;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (n_done < n_issued && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (n_done < n_issued) check("done_timeout", 32'(n_done), 32'(n_issued));
  endtask

  // monitor: request-change ordering and completion scoreboard
  initial begin
    logic [N-1:0] prev;
    logic [N-1:0] diff;
    int           bi;
    exp_t         e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        prev = halt_req_a;
      end else begin
        diff = prev ^ halt_req_a;
        if (diff != '0) begin
          bi = -1;
          for (int i = N - 1; i >= 0; i--) if (diff[i]) bi = i;
          if (req_q.size() == 0) begin
            check("req_unexpected", 32'(diff), 32'd0);
          end else begin
            check("req_one_bit", 32'($countones(diff)), 32'd1);
            check("req_order", 32'(bi), 32'(req_q[0]));
            void'(req_q.pop_front());
          end
        end
        prev = halt_req_a;
        if (done) begin
          if (exp_q.size() == 0) begin
            check("done_unexpected", 32'(done), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("halted", 32'(halted), 32'(e.halted));
            check("halt_req", 32'(halt_req_a), 32'(e.req));
            check("err_mask", 32'(err_mask), 32'(e.errm));
            check("err", 32'(err), 32'(e.err));
          end
          n_done++;
        end
      end
    end
  end

  initial begin
    int cnt_hi;
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    #1;
    check("rst_halt_req", 32'(halt_req_a), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err_mask", 32'(err_mask), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    // empty mask: SCAN then DONE
    issue(1'b1, '0);
    @(negedge clk);
    check("empty_scan_done", 32'(done), 32'd0);
    @(negedge clk);
    check("empty_done", 32'(done), 32'd1);
    wait_done();

    // halt then run cores 0 and 2, acks four cycles after request
    alive = '1;
    dly   = 4;
    issue(1'b1, 18'h00005);
    wait_done();
    issue(1'b0, 18'h00005);
    wait_done();

    // silent core 1 times out after TMO+1 WAIT cycles
    alive = ~18'h00002;
    issue(1'b1, 18'h00002);
    cnt_hi = 0;
    k = 0;
    while (n_done < n_issued && k < 60) begin
      @(negedge clk);
      if (halt_req_a[1]) cnt_hi++;
      k++;
    end
    check("tmo_wait_cycles", 32'(cnt_hi), 32'd9);
    wait_done();
    alive = '1;

    // a second request held during busy is ignored
    wait_ready();
    model_cmd(1'b1, 18'h00008);
    n_issued++;
    cmd_valid = 1'b1;
    cmd_halt  = 1'b1;
    cmd_mask  = 18'h00008;
    @(posedge clk);
    #1 cmd_mask = 18'h00010;
    repeat (4) begin
      @(negedge clk);
      check("busy_ready_low", 32'(cmd_ready), 32'd0);
      check("busy_high", 32'(busy), 32'd1);
    end
    cmd_valid = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check("no_second_accept", 32'(busy), 32'd0);
    check("core4_untouched", 32'(halted[4]), 32'd0);

    // randomized commands
    for (int t = 0; t < 40; t++) begin
      dly = $urandom_range(0, 4);
      for (int i = 0; i < N; i++) alive[i] = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(1'($urandom_range(0, 1)), N'($urandom));
      wait_done();
    end

    // reset while waiting on core 16
    alive = '1;
    dly   = 4;
    repeat (8) @(negedge clk);
    wait_ready();
    if (!m_req[16]) req_q.push_back(16);
    cmd_valid = 1'b1;
    cmd_halt  = 1'b1;
    cmd_mask  = 18'h30000;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    k = 0;
    while (!halt_req_a[16] && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rst_test_req16", 32'(halt_req_a[16]), 32'd1);
    @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    check("arst_halt_req", 32'(halt_req_a), 32'd0);
    check("arst_halted", 32'(halted), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_err_mask", 32'(err_mask), 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd0);
    exp_q.delete();
    req_q.delete();
    m_halted = '0;
    m_req    = '0;
    @(posedge clk);
    @(negedge clk);
    check("arst_no_done", 32'(done), 32'd0);
    rst_a = 1'b0;
    repeat (8) @(negedge clk);
    issue(1'b1, 18'h30000);
    wait_done();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/npu_arc_halt_seq.md
NPU_ARC_HALT_SEQ -- requirements
Module: npu_arc_halt_seq

Interface
REQ-001 SHALL have parameter N_CORES, default 18, meaning the number of ARC cores sequenced (2 L2 + 16 slice L1).
REQ-002 SHALL have parameter TMO_CYC, default 1023, meaning the maximum wait cycles per core before timeout (range 1..65535).
REQ-003 SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst_a as in the rest of the codebase.
REQ-004 clk  in  1  block clock, rising edge.
REQ-005 rst_a  in  1  asynchronous active-high reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accept, high only in IDLE.
REQ-008 cmd_halt  in  1  1 = halt cores in mask, 0 = run (release) cores in mask.
REQ-009 cmd_mask  in  N_CORES  cores targeted by the command.
REQ-010 halt_ack  in  N_CORES  per-core halt acknowledge, asynchronous to clk.
REQ-011 run_ack  in  N_CORES  per-core run acknowledge, asynchronous to clk.
REQ-012 halt_req_a  out  N_CORES  per-core halt request, level, registered.
REQ-013 halted  out  N_CORES  per-core halted status as tracked by the sequencer.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse at command completion.
REQ-016 err  out  1  one-cycle pulse with done when any core timed out.
REQ-017 err_mask  out  N_CORES  cores that timed out in the last command; held until the next accept.

Function
REQ-018 halt_ack and run_ack SHALL each pass through a 2-flop synchronizer; all decisions use the synchronized values (ack_s).
REQ-019 The FSM SHALL have exactly the states IDLE, SCAN, WAIT and DONE.
REQ-020 Command accept is cmd_valid & cmd_ready. On accept:
- latch op = cmd_halt
- latch rem = cmd_mask & (cmd_halt ? ~halted : halted)
- clear err_mask
- go to SCAN
REQ-021 Mask handling on accept:
- cores already in the requested state are skipped silently
- cmd_mask = 0, or an all-skipped mask, gives SCAN -> DONE
REQ-022 SCAN:
- if rem = 0, go to DONE
- otherwise select idx = lowest set bit of rem
- op=halt: set halt_req_a[idx] = 1; op=run: clear halt_req_a[idx] = 0
- clear the timeout counter and go to WAIT
- the halt_req_a change is visible the cycle after SCAN
REQ-023 WAIT, success (op=halt and halt_ack_s[idx] = 1, or op=run and run_ack_s[idx] = 1):
- update halted[idx] = op
- clear rem[idx]
- go to SCAN
REQ-024 WAIT, timeout (no success and counter = TMO_CYC):
- set err_mask[idx]
- clear rem[idx]
- if op=halt, drop halt_req_a[idx] to 0
- halted[idx] stays unchanged
- go to SCAN
- otherwise the counter increments by 1 per cycle, 16-bit, no wrap (saturates at TMO_CYC)
REQ-025 Success has priority over timeout when both hold in the same cycle.
REQ-026 DONE SHALL last exactly 1 cycle:
- done = 1
- err = |err_mask
- go to IDLE
REQ-027 Cores are processed strictly one at a time in ascending index order; at most one halt_req_a bit changes per SCAN.
REQ-028 cmd_valid while busy SHALL be ignored (not queued); cmd_mask bits at index >= N_CORES do not exist.
REQ-029 Minimum command latency, from accept to done:
- empty mask: 2 cycles (SCAN, DONE)
- per core: SCAN + WAIT cycles, where WAIT >= 3 cycles, counting from the halt_req_a change through the synchronizer
REQ-030 halt_req_a and halted bits of cores not being processed SHALL hold their values.

Reset
REQ-031 rst_a high SHALL asynchronously force the following, including mid-command; any in-flight command is discarded without a done pulse:
- state = IDLE
- halt_req_a, halted, err_mask, rem = 0
- synchronizer flops = 0
- counter = 0
- busy, done, err = 0
- cmd_ready = 1 from the first clk after rst_a deasserts
REQ-032 After reset deassertion, the first command SHALL be accepted on the first rising clk edge with cmd_valid = 1.

Verification
REQ-033 Halt cmd, mask = 0x00005, acks returned 4 cycles after req -> halt_req_a[0] then [2] rise in order; halted = 0x00005; done pulse; err = 0.
REQ-034 Run cmd, mask = 0x00005, after REQ-033 -> halt_req_a clears bit 0 then bit 2; run_ack observed; halted = 0; done with err = 0.
REQ-035 TMO_CYC = 8, halt cmd mask = 0x00002, no ack -> timeout after 9 WAIT cycles; halt_req_a[1] back to 0; err_mask = 0x00002; done and err pulse together.
REQ-036 Halt cmd mask = 0 -> done exactly 2 cycles after accept; no halt_req_a change; err = 0.
REQ-037 Halt cmd mask = 0x30000, rst_a pulsed while in WAIT for core 16 -> all outputs return to 0 asynchronously; no done pulse; a new command is accepted after release.
REQ-038 cmd_valid held high during a busy command with a different mask -> second command is not accepted until cmd_ready returns; state unaffected.
